// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display exercises.
// Segment order is {P,A,B,C,D,E,F,G}, segments active-high, digit enables active-low.
package seg_pkg;

  localparam int SEG_P = 7;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [7:0] SEG_DASH = 8'h01;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h5F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h7B;

  localparam logic [3:0] DIG_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to 7-segment glyph {A,B,C,D,E,F,G}.
// Non-decimal nibbles render as a dash.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; A-F fall through to a dash
  always_comb begin
    seg_o = SEG_DASH[6:0];
    case (nib_i)
      4'd0: seg_o = GLYPH_0;
      4'd1: seg_o = GLYPH_1;
      4'd2: seg_o = GLYPH_2;
      4'd3: seg_o = GLYPH_3;
      4'd4: seg_o = GLYPH_4;
      4'd5: seg_o = GLYPH_5;
      4'd6: seg_o = GLYPH_6;
      4'd7: seg_o = GLYPH_7;
      4'd8: seg_o = GLYPH_8;
      4'd9: seg_o = GLYPH_9;
      default: seg_o = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with frame-aligned updates.
// Define SEG_LZ_BLANK_EN to suppress leading zeros on digits 3..1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  output logic [3:0]  dig,
  output logic [7:0]  smg
);

  localparam int DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   act_q, act_d;
  logic [3:0]    adp_q, adp_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    pdp_q, pdp_d;
  logic          pv_q, pv_d;
  logic          rdy_q;
  logic [3:0]    dig_q, dig_d;
  logic [7:0]    smg_q, smg_d;

  logic [0:0] st;
  logic       wrap;
  logic       frame;
  logic       fire;
  logic [3:0] nib;
  logic [6:0] glyph;
  logic       lz;

  assign wrap  = (cnt_q == CW'(DIV - 1));
  assign frame = wrap && (idx_q == 2'd3);
  assign fire  = upd_valid && rdy_q;
  assign st    = (cnt_q < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;

  // Select the nibble of the digit currently being scanned
  always_comb begin
    nib = act_q[3:0];
    case (idx_q)
      2'd0: nib = act_q[3:0];
      2'd1: nib = act_q[7:4];
      2'd2: nib = act_q[11:8];
      2'd3: nib = act_q[15:12];
      default: nib = act_q[3:0];
    endcase
  end

  seg7_decode u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );

`ifdef SEG_LZ_BLANK_EN
  // Digit is blanked when it and every higher nibble are zero
  always_comb begin
    lz = 1'b0;
    case (idx_q)
      2'd3: lz = (act_q[15:12] == 4'd0);
      2'd2: lz = (act_q[15:8] == 8'd0);
      2'd1: lz = (act_q[15:4] == 12'd0);
      default: lz = 1'b0;
    endcase
  end
`else
  assign lz = 1'b0;
`endif

  // Slot timing, frame-aligned update and next output values
  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    act_d  = act_q;
    adp_d  = adp_q;
    pend_d = pend_q;
    pdp_d  = pdp_q;
    pv_d   = pv_q;
    if (frame && pv_q) begin
      act_d = pend_q;
      adp_d = pdp_q;
      pv_d  = 1'b0;
    end
    if (fire) begin
      pend_d = upd_data;
      pdp_d  = upd_dp;
      pv_d   = 1'b1;
    end
    dig_d = DIG_OFF;
    smg_d = SEG_OFF;
    if (st == ST_SHOW) begin
      dig_d = ~(4'b0001 << idx_q);
      smg_d = {adp_q[idx_q], lz ? 7'h00 : glyph};
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      act_q  <= 16'h0000;
      adp_q  <= 4'b0000;
      pend_q <= 16'h0000;
      pdp_q  <= 4'b0000;
      pv_q   <= 1'b0;
      rdy_q  <= 1'b1;
      dig_q  <= DIG_OFF;
      smg_q  <= SEG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      adp_q  <= adp_d;
      pend_q <= pend_d;
      pdp_q  <= pdp_d;
      pv_q   <= pv_d;
      rdy_q  <= !pv_d;
      dig_q  <= dig_d;
      smg_q  <= smg_d;
    end
  end

  assign upd_ready = rdy_q;
  assign dig       = dig_q;
  assign smg       = smg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with DIV=10, BLANK_CYCLES=2.
// Build with SEG_LZ_BLANK_EN to cover leading-zero suppression.
module tb_seg_scan_ctrl;

  localparam int CLK_HZ = 1000;
  localparam int SCAN   = 100;
  localparam int BL     = 2;
  localparam int DIV    = CLK_HZ / SCAN;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_data;
  logic [3:0]  upd_dp;
  logic [3:0]  dig;
  logic [7:0]  smg;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] smg;
    logic       rdy;
  } exp_t;

  exp_t q[$];

  int          m_cnt;
  int          m_idx;
  logic [15:0] m_act;
  logic [3:0]  m_dp;
  logic [15:0] m_pend;
  logic [3:0]  m_pdp;
  logic        m_pv;
  logic        m_fire;

  seg_scan_ctrl #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .SCAN_HZ      (SCAN),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_data  (upd_data),
    .upd_dp    (upd_dp),
    .dig       (dig),
    .smg       (smg)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(logic [3:0] n);
    logic [6:0] tbl [0:9];
    tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
            7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    if (n > 4'd9) return 7'h01;
    return tbl[n];
  endfunction

  function automatic logic [6:0] shown(int i);
    logic [3:0]  n;
    logic [15:0] hi;
    n  = m_act[4*i +: 4];
    hi = m_act >> (4 * i);
`ifdef SEG_LZ_BLANK_EN
    if (i > 0 && hi == 16'h0) return 7'h00;
`endif
    return glyph(n);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 0;
    m_act  = 16'h0;
    m_dp   = 4'h0;
    m_pend = 16'h0;
    m_pdp  = 4'h0;
    m_pv   = 1'b0;
    m_fire = 1'b0;
    q.delete();
  endtask

  // One clock: predict, advance model, then compare at the falling edge
  task automatic tick();
    exp_t e;
    exp_t g;
    logic bnd;
    if (m_cnt < BL) begin
      e.dig = 4'b1111;
      e.smg = 8'h00;
    end else begin
      e.dig = ~(4'b0001 << m_idx);
      e.smg = {m_dp[m_idx], shown(m_idx)};
    end
    m_fire = upd_valid && !m_pv;
    bnd = (m_cnt == DIV - 1) && (m_idx == 3);
    if (bnd && m_pv) begin
      m_act = m_pend;
      m_dp  = m_pdp;
      m_pv  = 1'b0;
    end
    if (m_fire) begin
      m_pend = upd_data;
      m_pdp  = upd_dp;
      m_pv   = 1'b1;
    end
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
    e.rdy = !m_pv;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = q.pop_front();
    check("dig", 32'(dig), 32'(g.dig));
    check("smg", 32'(smg), 32'(g.smg));
    check("rdy", 32'(upd_ready), 32'(g.rdy));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(logic [15:0] d, logic [3:0] p);
    int k;
    upd_valid = 1'b1;
    upd_data  = d;
    upd_dp    = p;
    k = 0;
    do begin
      tick();
      k++;
    end while (!m_fire && k < 200);
    if (!m_fire) begin
      failures++;
      $display("FAIL send_timeout data=%h", d);
    end
    upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_dig", 32'(dig), 32'hF);
    check("rst_smg", 32'(smg), 32'h0);
    check("rst_rdy", 32'(upd_ready), 32'h1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    rst_n     = 1'b1;
    upd_valid = 1'b0;
    upd_data  = 16'h0;
    upd_dp    = 4'h0;
    @(negedge clk);
    do_reset();

    run(80);

    run(15);
    send(16'h1234, 4'b0100);
    run(100);

    send(16'h1234, 4'b0100);
    send(16'h5678, 4'b0000);
    run(120);

    send(16'hA0F9, 4'b0000);
    run(90);

    send(16'h0042, 4'b0001);
    run(90);
    send(16'h0000, 4'b0000);
    run(90);

    send(16'h9876, 4'b1000);
    upd_valid = 1'b1;
    upd_data  = 16'h4321;
    upd_dp    = 4'b0010;
    k = 0;
    while (!(m_idx == 2 && m_cnt == 5 && m_pv) && k < 200) begin
      tick();
      k++;
    end
    upd_valid = 1'b0;
    if (k >= 200) begin
      failures++;
      $display("FAIL reset_setup_timeout idx=%0d", m_idx);
    end
    check("pre_rst_rdy", 32'(upd_ready), 32'h0);
    do_reset();
    run(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan controller for the 4-digit common-anode 7-segment display on the Runber board.
- Time-multiplexes one shared 8-bit segment bus across 4 digit enables; digit enables are active-low, segments active-high.
- Accepts new 4-digit BCD values plus decimal points over a valid/ready handshake and applies them only at frame boundaries, so a frame never mixes old and new digits.
- Sits between application counters/timers and the display pins; replaces static all-digits-on drive.

Parameters:
- CLK_FREQ_HZ, 12000000, input clock frequency.
- SCAN_HZ, 1000, digit slot rate; slot length DIV = CLK_FREQ_HZ/SCAN_HZ cycles; frame = 4*DIV cycles.
- BLANK_CYCLES, 12, all-off cycles at the start of each slot (anti-ghosting); must satisfy 1 <= BLANK_CYCLES < DIV.

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- upd_valid  in  1  update request.
- upd_ready  out  1  controller can accept an update.
- upd_data  in  16  BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3.
- upd_dp  in  4  decimal point per digit, bit i = digit i.
- dig  out  4  digit enables, active-low, dig[i] drives digit i.
- smg  out  8  segments, active-high: [7]=P, [6]=A, [5]=B, [4]=C, [3]=D, [2]=E, [1]=F, [0]=G.

Behaviour:
- Reset: dig=4'b1111, smg=8'h00, upd_ready=1, active value=16'h0000, active dp=4'b0000, pending empty, digit index=0, state=BLANK, slot counter=0. All outputs are registered.
- Slot counter counts 0..DIV-1 and wraps. State machine per slot:
  - BLANK: counter < BLANK_CYCLES; dig=1111, smg=00.
  - SHOW: counter >= BLANK_CYCLES; dig has a single 0 at the index position; smg = decode(active nibble) | (dp<<7).
- At wrap (counter==DIV-1), the index advances 0->1->2->3->0.
- Output timing: outputs reflect the state one cycle after the counter value, with a fixed 1-cycle pipeline.
- Frame boundary: the cycle in which the counter wraps and the index goes 3->0.
- Pending buffer:
  - One entry plus a pend_vld flag; upd_ready = !pend_vld (registered).
  - Handshake fires when upd_valid && upd_ready; data and dp are captured into pending and pend_vld is set.
  - At a frame boundary with pend_vld=1: active<=pending and pend_vld<=0.
  - If a handshake cannot occur in that cycle (ready=0), there is no overlap case. Only one update is applied per frame.
  - Updates arriving while pending is full are back-pressured; the requester holds upd_valid and upd_data stable until the handshake.
- Decode (nibble -> smg[6:0]):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - Nibbles A-F display "-" (G only, 7'h01).
- Asserting rst_n low at any time, including mid-slot or with pending full, returns all state to reset values immediately. The first slot after release is digit 0, starting in BLANK.
- Display duty per digit = (DIV-BLANK_CYCLES)/(4*DIV).

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit i (i=3..1) shows smg[6:0]=0 if its nibble and every higher nibble are 0. Digit 0 is always shown. The DP bit is still driven from active dp. dig still scans normally.
- Undefined: every digit is decoded, e.g. 0x0042 shows "0042".

Decomposition:
- Shared package seg_pkg: segment bit positions, SEG_DASH=8'h01, SEG_OFF=8'h00, the 7-bit glyph constants for 0-9, and DIG_OFF=4'b1111.
- One sub-module seg7_decode: combinational nibble -> 7-bit glyph, instantiated once on the muxed nibble. Reusable by other board exercises.

Test Plan (CLK_FREQ_HZ=1000, SCAN_HZ=100 -> DIV=10, BLANK_CYCLES=2):
1. Reset then idle -> dig sequence 1110, 1101, 1011, 0111 repeating every 40 cycles; smg=7E during SHOW (8 cycles/slot); dig=1111 and smg=00 for 2 cycles per slot.
2. Send upd_data=16'h1234, dp=4'b0100 mid-frame -> no change until the next frame boundary. Then digit0 smg=33, digit1 smg=79, digit2 smg=ED (DP set), digit3 smg=30.
3. Hold upd_valid with a second value 16'h5678 right after the first handshake -> upd_ready=0 until the boundary. 1234 shows for one full frame, then 5678 the next frame; no frame mixes values.
4. upd_data=16'hA0F9 -> digit3 and digit1 show 01; digit2 shows 7E; digit0 shows 7B.
5. Assert rst_n low mid-SHOW of digit 2 with pending full -> dig=1111, smg=00 and upd_ready=1 immediately. After release, digit0 BLANK comes first and "0000" is shown.
6. With SEG_LZ_BLANK_EN defined, value 16'h0042 -> digits 3 and 2 have smg=00 during SHOW; digit1=33, digit0=6D. Value 16'h0000 -> only digit0 shows 7E.
